updi_transaction_sequencer: RTL and testbench

UPDI_TRANSACTION_SEQUENCER -- requirements
Module: updi_transaction_sequencer

---
 rtl/updi_pkg.sv | 30 +++
 rtl/updi_instruction_converter.sv | 40 ++++
 rtl/updi_transaction_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_updi_transaction_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/updi_pkg.sv
// Shared UPDI definitions: instruction set, protocol constants and small helpers.
package updi_pkg;

  // Encoding matches opcode[7:5] of the UPDI instruction byte.
  typedef enum logic [2:0] {
    UPDI_LDS    = 3'd0,
    UPDI_LD     = 3'd1,
    UPDI_STS    = 3'd2,
    UPDI_ST     = 3'd3,
    UPDI_LDCS   = 3'd4,
    UPDI_REPEAT = 3'd5,
    UPDI_STCS   = 3'd6,
    UPDI_KEY    = 3'd7
  } updi_instruction;

  localparam logic [7:0] UPDI_SYNCH       = 8'h55;
  localparam logic [7:0] UPDI_ACK_DEFAULT = 8'h40;

  // Instructions the sequencer knows how to run end to end.
  function automatic logic is_supported(input updi_instruction instr);
    return (instr == UPDI_LDS) || (instr == UPDI_STS) ||
           (instr == UPDI_LDCS) || (instr == UPDI_STCS);
  endfunction

  // Index of the last address byte; the reserved size code 3 is treated as 3 bytes.
  function automatic logic [1:0] addr_last_idx(input logic [1:0] size_a);
    return (size_a == 2'd3) ? 2'd2 : size_a;
  endfunction

endpackage

// File: rtl/updi_instruction_converter.sv
// Builds the UPDI opcode byte from a host command; captured when enable is high.
module updi_instruction_converter
  import updi_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  updi_instruction instruction,
  input  logic [1:0]      size_a,
  input  logic [1:0]      size_b,
  input  logic [3:0]      cs_addr,
  output logic [7:0]      opcode
);

  logic [7:0] opcode_q, opcode_d;

  // Encode the opcode fields for the presented instruction.
  always_comb begin
    opcode_d = opcode_q;
    if (enable) begin
      case (instruction)
        UPDI_LDS, UPDI_LD, UPDI_STS, UPDI_ST:
          opcode_d = {instruction, 1'b0, addr_last_idx(size_a), size_b};
        UPDI_LDCS, UPDI_STCS:
          opcode_d = {instruction, 1'b0, cs_addr};
        default:
          opcode_d = {instruction, 5'b0};
      endcase
    end
  end

  // Hold the opcode for the duration of the transaction.
  always_ff @(posedge clk) begin
    if (rst) opcode_q <= 8'h00;
    else     opcode_q <= opcode_d;
  end

  assign opcode = opcode_q;

endmodule

// File: rtl/updi_transaction_sequencer.sv
// Runs one UPDI transaction per host command: SYNCH, opcode, address, data, ACK handling.
module updi_transaction_sequencer
  import updi_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter logic [7:0] ACK_BYTE       = UPDI_ACK_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  updi_instruction req_instruction,
  input  logic [1:0]      req_size_a,
  input  logic [1:0]      req_size_b,
  input  logic [3:0]      req_cs_addr,
  input  logic [23:0]     req_addr,
  input  logic [15:0]     req_wdata,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic [7:0]      tx_data,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            rsp_valid,
  output logic [15:0]     rsp_rdata,
  output logic            rsp_error
);

  localparam int TIMER_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNCH, ST_OPCODE, ST_ADDR, ST_WAIT_ACK, ST_DATA_TX, ST_DATA_RX, ST_RESP
  } state_t;

  state_t          state_q, state_d;
  updi_instruction instr_q, instr_d;
  logic [1:0]      size_a_q, size_a_d;
  logic [1:0]      size_b_q, size_b_d;
  logic [23:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic            data_done_q, data_done_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            req_ready_q, req_ready_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [15:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_error_q, rsp_error_d;

  logic       accept;
  logic [7:0] opcode;
  logic       data_last;

  assign accept = req_valid && req_ready_q;
  // Control/status transfers always move a single byte.
  assign data_last = (instr_q == UPDI_LDCS || instr_q == UPDI_STCS) ? 1'b0 : (size_b_q != 2'd0);

  updi_instruction_converter u_converter (
    .clk         (clk),
    .rst         (rst),
    .enable      (accept),
    .instruction (req_instruction),
    .size_a      (req_size_a),
    .size_b      (req_size_b),
    .cs_addr     (req_cs_addr),
    .opcode      (opcode)
  );

  // Next-state and next-output logic for the transaction sequence.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    size_a_d    = size_a_q;
    size_b_d    = size_b_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    byte_idx_d  = byte_idx_q;
    timer_d     = timer_q;
    data_done_d = data_done_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    case (state_q)
      ST_IDLE: if (accept) begin
        instr_d     = req_instruction;
        size_a_d    = req_size_a;
        size_b_d    = req_size_b;
        addr_d      = req_addr;
        wdata_d     = req_wdata;
        byte_idx_d  = 2'd0;
        data_done_d = 1'b0;
        rdata_d     = 16'h0000;
        err_d       = !is_supported(req_instruction);
        state_d     = is_supported(req_instruction) ? ST_SYNCH : ST_RESP;
      end
      ST_SYNCH: if (tx_ready) state_d = ST_OPCODE;
      ST_OPCODE: if (tx_ready) begin
        byte_idx_d = 2'd0;
        timer_d    = '0;
        case (instr_q)
          UPDI_LDS, UPDI_STS: state_d = ST_ADDR;
          UPDI_LDCS:          state_d = ST_DATA_RX;
          UPDI_STCS:          state_d = ST_DATA_TX;
          default: begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        endcase
      end
      ST_ADDR: if (tx_ready) begin
        if (byte_idx_q == addr_last_idx(size_a_q)) begin
          byte_idx_d = 2'd0;
          timer_d    = '0;
          state_d    = (instr_q == UPDI_LDS) ? ST_DATA_RX : ST_WAIT_ACK;
        end else begin
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      ST_WAIT_ACK: begin
        if (rx_valid) begin
          timer_d = '0;
          if (rx_data != ACK_BYTE) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (data_done_q) begin
            state_d = ST_RESP;
          end else begin
            byte_idx_d = 2'd0;
            state_d    = ST_DATA_TX;
          end
        end else if (timer_q >= TIMER_LIMIT) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_DATA_TX: if (tx_ready) begin
        if (byte_idx_q[0] == data_last) begin
          byte_idx_d = 2'd0;
          if (instr_q == UPDI_STS) begin
            data_done_d = 1'b1;
            timer_d     = '0;
            state_d     = ST_WAIT_ACK;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      ST_DATA_RX: begin
        if (rx_valid) begin
          timer_d = '0;
          if (byte_idx_q[0]) rdata_d[15:8] = rx_data;
          else               rdata_d[7:0]  = rx_data;
          if (byte_idx_q[0] == data_last) state_d = ST_RESP;
          else                            byte_idx_d = byte_idx_q + 2'd1;
        end else if (timer_q >= TIMER_LIMIT) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are derived from the upcoming state so they register cleanly.
    req_ready_d = (state_d == ST_IDLE);
    tx_valid_d  = (state_d == ST_SYNCH) || (state_d == ST_OPCODE) ||
                  (state_d == ST_ADDR) || (state_d == ST_DATA_TX);
    case (state_d)
      ST_SYNCH:   tx_data_d = UPDI_SYNCH;
      ST_OPCODE:  tx_data_d = opcode;
      ST_ADDR: begin
        case (byte_idx_d)
          2'd0:    tx_data_d = addr_d[7:0];
          2'd1:    tx_data_d = addr_d[15:8];
          default: tx_data_d = addr_d[23:16];
        endcase
      end
      ST_DATA_TX: tx_data_d = byte_idx_d[0] ? wdata_d[15:8] : wdata_d[7:0];
      default:    tx_data_d = 8'h00;
    endcase
    rsp_valid_d = (state_d == ST_RESP);
    if (state_d == ST_RESP) begin
      rsp_rdata_d = rdata_d;
      rsp_error_d = err_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      instr_q     <= UPDI_LDS;
      size_a_q    <= 2'd0;
      size_b_q    <= 2'd0;
      addr_q      <= 24'h0;
      wdata_q     <= 16'h0;
      byte_idx_q  <= 2'd0;
      timer_q     <= '0;
      data_done_q <= 1'b0;
      rdata_q     <= 16'h0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      size_a_q    <= size_a_d;
      size_b_q    <= size_b_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      byte_idx_q  <= byte_idx_d;
      timer_q     <= timer_d;
      data_done_q <= data_done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready = req_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_updi_transaction_sequencer.sv
// Scoreboard bench for the UPDI transaction sequencer.
module tb_updi_transaction_sequencer;
  import updi_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  updi_instruction req_instruction = UPDI_LDS;
  logic [1:0]      req_size_a = 2'd0;
  logic [1:0]      req_size_b = 2'd0;
  logic [3:0]      req_cs_addr = 4'd0;
  logic [23:0]     req_addr = 24'h0;
  logic [15:0]     req_wdata = 16'h0;
  logic            tx_valid;
  logic            tx_ready = 1'b1;
  logic [7:0]      tx_data;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rsp_valid;
  logic [15:0]     rsp_rdata;
  logic            rsp_error;

  int compared = 0;
  int mismatched = 0;
  logic [7:0]  tx_q[$];
  logic [16:0] rsp_q[$];
  logic        tx_valid_seen = 1'b0;

  updi_transaction_sequencer #(.TIMEOUT_CYCLES(16), .ACK_BYTE(8'h40)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_instruction(req_instruction),
    .req_size_a(req_size_a), .req_size_b(req_size_b), .req_cs_addr(req_cs_addr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic flag(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Monitor: pop and compare whenever the DUT completes a TX byte or a response.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid) tx_valid_seen = 1'b1;
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL tx_unexpected: got %h required no byte", tx_data);
        end else begin
          check("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
        end
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL rsp_unexpected: got %h/%b required no response", rsp_rdata, rsp_error);
        end else begin
          check("rsp_rdata_error", {15'h0, rsp_rdata, rsp_error}, {15'h0, rsp_q.pop_front()});
        end
      end
    end
  end

  task automatic issue(input updi_instruction ins, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [3:0] cs, input logic [23:0] a, input logic [15:0] wd);
    logic accepted;
    int n;
    req_instruction = ins;
    req_size_a = sa;
    req_size_b = sb;
    req_cs_addr = cs;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 20) begin
      accepted = req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    if (!accepted) flag("req_accept_timeout");
  endtask

  task automatic wait_tx_empty(input int budget);
    int n = 0;
    while (tx_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (tx_q.size() != 0) begin
      flag("tx_wait_timeout");
      tx_q.delete();
    end
  endtask

  task automatic wait_rsp_empty(input int budget);
    int n = 0;
    while (rsp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (rsp_q.size() != 0) begin
      flag("rsp_wait_timeout");
      rsp_q.delete();
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", {31'h0, req_ready}, 32'd1);
    check("reset_tx_valid", {31'h0, tx_valid}, 32'd0);
    check("reset_tx_data", {24'h0, tx_data}, 32'h0);
    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", {16'h0, rsp_rdata}, 32'h0);
    check("reset_rsp_error", {31'h0, rsp_error}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // LDS, 2-byte address, 1-byte data.
    tx_q = '{8'h55, 8'h04, 8'h34, 8'h12};
    rsp_q.push_back({16'h00AB, 1'b0});
    issue(UPDI_LDS, 2'd1, 2'd0, 4'd0, 24'h001234, 16'h0);
    wait_tx_empty(40);
    send_rx(8'hAB);
    wait_rsp_empty(40);

    // STS, 1-byte address, 2-byte data, both ACKs good.
    tx_q = '{8'h55, 8'h41, 8'h20};
    rsp_q.push_back({16'h0000, 1'b0});
    issue(UPDI_STS, 2'd0, 2'd1, 4'd0, 24'h000020, 16'hBEEF);
    wait_tx_empty(40);
    tx_q.push_back(8'hEF);
    tx_q.push_back(8'hBE);
    send_rx(8'h40);
    wait_tx_empty(40);
    send_rx(8'h40);
    wait_rsp_empty(40);

    // STS with a bad first ACK: no data bytes may follow.
    tx_q = '{8'h55, 8'h41, 8'h20};
    rsp_q.push_back({16'h0000, 1'b1});
    issue(UPDI_STS, 2'd0, 2'd1, 4'd0, 24'h000020, 16'hBEEF);
    wait_tx_empty(40);
    send_rx(8'h00);
    wait_rsp_empty(40);
    repeat (4) @(posedge clk);
    #1;

    // LDS with reserved address size 3 (3 bytes) and 2 data bytes.
    tx_q = '{8'h55, 8'h09, 8'hEF, 8'hCD, 8'hAB};
    rsp_q.push_back({16'h2211, 1'b0});
    issue(UPDI_LDS, 2'd3, 2'd1, 4'd0, 24'hABCDEF, 16'h0);
    wait_tx_empty(40);
    send_rx(8'h11);
    send_rx(8'h22);
    wait_rsp_empty(40);

    // LDCS with a stray RX byte during SYNCH that must be ignored.
    tx_q = '{8'h55, 8'h82};
    rsp_q.push_back({16'h005A, 1'b0});
    issue(UPDI_LDCS, 2'd0, 2'd0, 4'd2, 24'h0, 16'h0);
    send_rx(8'h99);
    wait_tx_empty(40);
    send_rx(8'h5A);
    wait_rsp_empty(40);

    // LDCS with a stalled TX and no RX: data must hold, then timeout error.
    tx_ready = 1'b0;
    tx_q = '{8'h55, 8'h80};
    rsp_q.push_back({16'h0000, 1'b1});
    issue(UPDI_LDCS, 2'd0, 2'd0, 4'd0, 24'h0, 16'h0);
    n = 0;
    while (!tx_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_tx_valid", {31'h0, tx_valid}, 32'd1);
      check("stall_tx_data", {24'h0, tx_data}, 32'h55);
    end
    tx_ready = 1'b1;
    wait_tx_empty(40);
    wait_rsp_empty(60);

    // KEY is unsupported: error response, no TX activity.
    tx_valid_seen = 1'b0;
    rsp_q.push_back({16'h0000, 1'b1});
    issue(UPDI_KEY, 2'd0, 2'd0, 4'd0, 24'h0, 16'h0);
    wait_rsp_empty(20);
    check("key_no_tx", {31'h0, tx_valid_seen}, 32'd0);

    // Reset in the middle of the address phase aborts silently.
    tx_q = '{8'h55, 8'h08};
    issue(UPDI_LDS, 2'd2, 2'd0, 4'd0, 24'h123456, 16'h0);
    wait_tx_empty(40);
    tx_ready = 1'b0;
    check("addr_tx_valid", {31'h0, tx_valid}, 32'd1);
    check("addr_tx_data", {24'h0, tx_data}, 32'h56);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_req_ready", {31'h0, req_ready}, 32'd1);
    check("abort_tx_valid", {31'h0, tx_valid}, 32'd0);
    check("abort_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    rst = 1'b0;
    tx_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;

    // STCS after the abort: one data byte, clean completion.
    tx_q = '{8'h55, 8'hC3, 8'h77};
    rsp_q.push_back({16'h0000, 1'b0});
    issue(UPDI_STCS, 2'd0, 2'd0, 4'd3, 24'h0, 16'h1277);
    wait_tx_empty(40);
    wait_rsp_empty(40);
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
